seg_scan_driver: RTL and testbench

- Consumer side of the TrafficLight 7-segment cell interface. Takes the four 8-bit cell patterns (Cell0_i..Cell3_i) produced by the traffic display encoder and time-multiplexes them onto a common-anode 4-digit display.
- Scans the digits in turn, with a ghosting blank at the start of each digit slot, frame-coherent input capture, and PWM brightness.
- Sits between the TrafficLight encoder and the board pins.

---
 rtl/seg_scan_driver_if.sv | 11 +
 rtl/seg_scan_driver.sv | 87 ++++++++
 tb/tb_seg_scan_driver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Cell pattern bus from the traffic display encoder (master) to the scan driver (slave).
// Each cell holds segments g..a in [6:0] and the decimal point in [7], all active-low.
interface seg_scan_driver_if;
  logic [7:0] Cell0_i;
  logic [7:0] Cell1_i;
  logic [7:0] Cell2_i;
  logic [7:0] Cell3_i;

  modport master (output Cell0_i, output Cell1_i, output Cell2_i, output Cell3_i);
  modport slave  (input  Cell0_i, input  Cell1_i, input  Cell2_i, input  Cell3_i);
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexes four cell patterns onto a common-anode 4-digit display.
// Each digit slot opens with an all-off blank window, and PWM gates the active part.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_driver_if.slave    cells,
  input  logic                en_i,
  input  logic [2:0]          bright_i,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [3:0]          an_o,
  output logic                frame_sync_o
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TMR_TOP = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] ACT_TOP = CW'(REFRESH_DIV - 1 - BLANK_CYCLES);

  // slot_tmr counts down from TMR_TOP, so slot position cnt = TMR_TOP - slot_tmr
  logic [CW-1:0] slot_tmr;
  logic [1:0]    idx;
  logic [2:0]    pwm;
  logic [7:0]    frame [4];

  logic       slot_end;
  logic       snap;
  logic       on;
  logic [7:0] sel_cell;

  assign slot_end = (slot_tmr == '0);
  assign snap     = (slot_tmr == TMR_TOP) && (idx == 2'd0);
  assign sel_cell = frame[idx];
  assign on       = en_i && (slot_tmr <= ACT_TOP) && (pwm <= bright_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_tmr <= TMR_TOP;
      idx      <= 2'd0;
      pwm      <= 3'd0;
    end else begin
      pwm <= pwm + 3'd1;
      if (slot_end) begin
        slot_tmr <= TMR_TOP;
        idx      <= idx + 2'd1;
      end else begin
        slot_tmr <= slot_tmr - 1'b1;
      end
    end
  end

  // All four cells are captured together so every digit of a frame is coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) frame[k] <= 8'hFF;
    end else if (snap) begin
      frame[0] <= cells.Cell0_i;
      frame[1] <= cells.Cell1_i;
      frame[2] <= cells.Cell2_i;
      frame[3] <= cells.Cell3_i;
    end
  end

  // Segments are only driven while an anode is on, which keeps ghosting out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_o         <= 4'b1111;
      seg_o        <= 7'h7F;
      dp_o         <= 1'b1;
      frame_sync_o <= 1'b0;
    end else begin
      frame_sync_o <= snap;
      if (on) begin
        an_o  <= ~(4'b0001 << idx);
        seg_o <= sel_cell[6:0];
        dp_o  <= sel_cell[7];
      end else begin
        an_o  <= 4'b1111;
        seg_o <= 7'h7F;
        dp_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (8- and 64-cycle slots) checked every cycle
// against a time-index reference model, plus directed tables and corner sequences.
module tb_seg_scan_driver;
  localparam int RA = 8;
  localparam int RB = 64;
  localparam int BL = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       sync;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_i = 1'b0;
  logic [2:0] bright_i = 3'd0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;
  logic       sync_a, sync_b;

  seg_scan_driver_if cif ();

  seg_scan_driver #(.REFRESH_DIV(RA), .BLANK_CYCLES(BL)) dut_a (
    .clk(clk), .rst(rst), .cells(cif), .en_i(en_i), .bright_i(bright_i),
    .seg_o(seg_a), .dp_o(dp_a), .an_o(an_a), .frame_sync_o(sync_a));

  seg_scan_driver #(.REFRESH_DIV(RB), .BLANK_CYCLES(BL)) dut_b (
    .clk(clk), .rst(rst), .cells(cif), .en_i(en_i), .bright_i(bright_i),
    .seg_o(seg_b), .dp_o(dp_b), .an_o(an_b), .frame_sync_o(sync_b));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  logic [31:0] mfa, mfb;
  out_t        loga [64];

  // Reference: state at cycle tt after release is cnt = tt mod r, digit = (tt / r) mod 4,
  // pwm = tt mod 8; output registered at the edge that ends cycle tt.
  function automatic out_t model(input int r, input int tt, input logic [31:0] fr,
                                 input logic en, input logic [2:0] br);
    int         cnt;
    int         dig;
    int         ph;
    logic [7:0] c;
    out_t       o;
    cnt    = tt % r;
    dig    = (tt / r) % 4;
    ph     = tt % 8;
    c      = fr[dig*8 +: 8];
    o.sync = ((tt % (4 * r)) == 0);
    if (en && cnt >= BL && ph <= int'(br)) begin
      o.an      = 4'b1111;
      o.an[dig] = 1'b0;
      o.seg     = c[6:0];
      o.dp      = c[7];
    end else begin
      o.an  = 4'b1111;
      o.seg = 7'h7F;
      o.dp  = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, exp);
    end
  endtask

  function automatic logic [31:0] cells_now();
    return {cif.Cell3_i, cif.Cell2_i, cif.Cell1_i, cif.Cell0_i};
  endfunction

  task automatic step();
    out_t ea, eb;
    out_t aa, ab;
    ea = model(RA, t, mfa, en_i, bright_i);
    eb = model(RB, t, mfb, en_i, bright_i);
    if ((t % (4 * RA)) == 0) mfa = cells_now();
    if ((t % (4 * RB)) == 0) mfb = cells_now();
    @(posedge clk);
    #1;
    aa = {an_a, seg_a, dp_a, sync_a};
    ab = {an_b, seg_b, dp_b, sync_b};
    chk("out_a", 32'(aa), 32'(ea));
    chk("out_b", 32'(ab), 32'(eb));
    chk("onehot_a", 32'($onehot0(~an_a)), 32'd1);
    chk("onehot_b", 32'($onehot0(~an_b)), 32'd1);
    if (t < 64) loga[t] = aa;
    t++;
  endtask

  task automatic release_rst();
    rst = 1'b1;
    t   = 0;
    mfa = 32'hFFFF_FFFF;
    mfb = 32'hFFFF_FFFF;
  endtask

  initial begin
    vec_t       tbl [12];
    int         cnt;
    logic [3:0] first_lit;

    tbl[0]  = '{0,  '{4'hF, 7'h7F, 1'b1, 1'b1}};
    tbl[1]  = '{1,  '{4'hF, 7'h7F, 1'b1, 1'b0}};
    tbl[2]  = '{2,  '{4'hE, 7'h40, 1'b1, 1'b0}};
    tbl[3]  = '{7,  '{4'hE, 7'h40, 1'b1, 1'b0}};
    tbl[4]  = '{8,  '{4'hF, 7'h7F, 1'b1, 1'b0}};
    tbl[5]  = '{10, '{4'hD, 7'h79, 1'b1, 1'b0}};
    tbl[6]  = '{15, '{4'hD, 7'h79, 1'b1, 1'b0}};
    tbl[7]  = '{17, '{4'hF, 7'h7F, 1'b1, 1'b0}};
    tbl[8]  = '{18, '{4'hB, 7'h24, 1'b1, 1'b0}};
    tbl[9]  = '{26, '{4'h7, 7'h30, 1'b1, 1'b0}};
    tbl[10] = '{31, '{4'h7, 7'h30, 1'b1, 1'b0}};
    tbl[11] = '{32, '{4'hF, 7'h7F, 1'b1, 1'b1}};

    cif.Cell0_i = 8'h12;
    cif.Cell1_i = 8'h34;
    cif.Cell2_i = 8'h56;
    cif.Cell3_i = 8'h78;
    en_i = 1'b1;
    bright_i = 3'd7;

    // reset hold
    repeat (5) @(posedge clk);
    #1;
    chk("reset_a", 32'({an_a, seg_a, dp_a, sync_a}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    chk("reset_b", 32'({an_b, seg_b, dp_b, sync_b}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));

    // full-brightness scan
    cif.Cell0_i = 8'hC0;
    cif.Cell1_i = 8'hF9;
    cif.Cell2_i = 8'hA4;
    cif.Cell3_i = 8'hB0;
    release_rst();
    repeat (40) step();
    for (int i = 0; i < 12; i++)
      chk($sformatf("scan_t%0d", tbl[i].cyc), 32'(loga[tbl[i].cyc]), 32'(tbl[i].exp));

    // frame coherence: t=40 is inside digit 1 of the second frame
    cif.Cell2_i = 8'h00;
    while ((t % 32) != 20) step();
    step();
    chk("coh_cur_seg", 32'({an_a, seg_a, dp_a}), 32'({4'hB, 7'h24, 1'b1}));
    while ((t % 32) != 20) step();
    step();
    chk("coh_next_seg", 32'({an_a, seg_a, dp_a}), 32'({4'hB, 7'h00, 1'b0}));

    // PWM on the 64-cycle instance over one aligned frame
    while ((t % 256) != 0) step();
    bright_i = 3'd0;
    cnt = 0;
    repeat (256) begin
      step();
      if (an_b != 4'hF) cnt++;
    end
    chk("pwm_bright0", 32'(cnt), 32'd28);
    bright_i = 3'd3;
    cnt = 0;
    repeat (256) begin
      step();
      if (an_b != 4'hF) cnt++;
    end
    chk("pwm_bright3", 32'(cnt), 32'd120);

    // enable gating
    bright_i = 3'd7;
    en_i = 1'b0;
    cnt = 0;
    repeat (20) begin
      step();
      if (an_a != 4'hF || an_b != 4'hF) cnt++;
    end
    chk("en_off_lit", 32'(cnt), 32'd0);
    en_i = 1'b1;
    repeat (40) step();

    // randomized traffic against the model
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) begin
        cif.Cell0_i = 8'($urandom);
        cif.Cell1_i = 8'($urandom);
        cif.Cell2_i = 8'($urandom);
        cif.Cell3_i = 8'($urandom);
      end
      bright_i = 3'($urandom);
      en_i     = ($urandom_range(0, 5) != 0);
      step();
    end

    // reset during digit 3's active window
    bright_i = 3'd7;
    en_i = 1'b1;
    while ((t % 32) != 28) step();
    step();
    chk("pre_rst_an", 32'(an_a), 32'h7);
    rst = 1'b0;
    #1;
    chk("rst_async", 32'({an_a, seg_a, dp_a, sync_a}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    repeat (3) @(posedge clk);
    #1;
    release_rst();
    first_lit = 4'hF;
    repeat (12) begin
      step();
      if (first_lit == 4'hF && an_a != 4'hF) first_lit = an_a;
    end
    chk("first_after_rst", 32'(first_lit), 32'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
